cia_serial_add: RTL

- Multi-limb serial adder controller wrapped around the existing 8-bit carry-increment adder `cia`.
- Accepts two NLIMBS×8-bit operands through a valid/ready handshake.
- Feeds the 8-bit adder one limb per cycle, LSB limb first, and registers `cout` back into `cin` for the next limb.
- Presents the wide sum and final carry through an output valid/ready handshake.
- Sits directly upstream of, and wraps, the 8-bit adder stage; used to build wide additions from the narrow adder.

---
 rtl/cia_pkg.sv | 22 ++
 rtl/cia.sv | 21 ++
 rtl/cia_serial_add.sv | 106 ++++++++++
 3 files changed

// File: rtl/cia_pkg.sv
// Shared definitions for the serial multi-limb adder built on the 8-bit cia adder.
package cia_pkg;

    localparam int unsigned LIMB_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n limbs, never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/cia.sv
// 8-bit carry-increment adder: low nibble ripples, high nibble picks sum or sum+1.
module cia (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cin);
    assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1 = hi0 + 5'd1;

    assign s[3:0]          = lo[3:0];
    assign {cout, s[7:4]}  = lo[4] ? hi1 : hi0;

endmodule

// File: rtl/cia_serial_add.sv
// Wide adder that feeds the 8-bit cia one limb per cycle, LSB limb first.
// Optional subtract mode (in_sub port) is enabled with CIA_SERIAL_SUB_EN.
module cia_serial_add
    import cia_pkg::*;
#(
    parameter int unsigned NLIMBS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LIMB_W*NLIMBS-1:0] in_a,
    input  logic [LIMB_W*NLIMBS-1:0] in_b,
    input  logic                     in_cin,
`ifdef CIA_SERIAL_SUB_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LIMB_W*NLIMBS-1:0] out_sum,
    output logic                     out_cout
);

    localparam int unsigned W     = LIMB_W * NLIMBS;
    localparam int unsigned CNT_W = clog2(NLIMBS);

    state_t             state;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       sum_sh;
    logic [W-1:0]       sum_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [LIMB_W-1:0]  s8;
    logic               cout8;
    logic               load_sub;

    cia u_cia (
        .a    (a_sh[LIMB_W-1:0]),
        .b    (b_sh[LIMB_W-1:0]),
        .cin  (carry),
        .s    (s8),
        .cout (cout8)
    );

`ifdef CIA_SERIAL_SUB_EN
    assign load_sub = in_sub;
`else
    assign load_sub = 1'b0;
`endif

    assign in_ready = (state == IDLE);

    // New limb enters at the top so the LSB limb ends up at bit 0 after NLIMBS shifts.
    assign sum_nxt = (sum_sh >> LIMB_W) | (W'(s8) << (W - LIMB_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= in_a;
                        b_sh  <= load_sub ? ~in_b : in_b;
                        carry <= load_sub | in_cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= sum_nxt;
                    carry  <= cout8;
                    a_sh   <= a_sh >> LIMB_W;
                    b_sh   <= b_sh >> LIMB_W;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NLIMBS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_sum   <= sum_nxt;
                        out_cout  <= cout8;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
